// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared width derivation and FSM encoding for the adder_tree feeder
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } feeder_state_t;

    function automatic int result_width(input int data_width, input int weight_width);
        return data_width + weight_width;
    endfunction

    // Each doubling level of the tree adds one bit; KERNEL_SIZE bits is a safe upper bound.
    function automatic int sum_width(input int data_width, input int weight_width, input int kernel_size);
        return data_width + weight_width + kernel_size;
    endfunction

endpackage

// File: rtl/binary_weight_mul.sv
// rtl/binary_weight_mul.sv - one lane: unsigned pixel gated by a binary weight
module binary_weight_mul #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 9
) (
    input  logic [DATA_WIDTH-1:0]   pixel,
    input  logic                    weight,
    output logic [RESULT_WIDTH-1:0] product
);

    assign product = weight ? RESULT_WIDTH'(pixel) : '0;

endmodule

// File: rtl/adder_tree_feeder.sv
// rtl/adder_tree_feeder.sv - launches one kernel window into adder_tree and returns its sum
module adder_tree_feeder
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int WEIGHT_WIDTH   = 1,
    parameter int KERNEL_SIZE    = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16,
    localparam int RESULT_WIDTH  = result_width(DATA_WIDTH, WEIGHT_WIDTH),
    localparam int SUM_WIDTH     = sum_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]   in_data,
    input  logic [KERNEL_SIZE-1:0]              in_weight,
    output logic                                adder_en,
    output logic [RESULT_WIDTH*KERNEL_SIZE-1:0] adder_dataIn,
    input  logic [SUM_WIDTH-1:0]                adder_dataOut,
    input  logic                                adder_done,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SUM_WIDTH-1:0]                out_data,
    output logic                                err_timeout,
    output logic [CNT_WIDTH-1:0]                job_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    feeder_state_t state, state_nxt;
    logic [TW-1:0] wait_cnt;
    logic [RESULT_WIDTH*KERNEL_SIZE-1:0] products;
    logic wait_last;

    for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_lane
        binary_weight_mul #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESULT_WIDTH(RESULT_WIDTH)
        ) u_mul (
            .pixel  (in_data[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]),
            .weight (in_weight[i]),
            .product(products[(i+1)*RESULT_WIDTH-1 -: RESULT_WIDTH])
        );
    end

    assign wait_last = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // adder_done only matters in WAIT; a done that coincides with timeout still completes the job.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_FIRE;
            ST_FIRE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (adder_done)     state_nxt = ST_OUT;
                else if (wait_last) state_nxt = ST_IDLE;
            end
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        adder_en  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready  = rstn;
            ST_FIRE: adder_en  = 1'b1;
            ST_OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            adder_dataIn <= '0;
            out_data     <= '0;
            err_timeout  <= 1'b0;
            job_cnt      <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) adder_dataIn <= products;
                ST_FIRE: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + TW'(1);
                    if (adder_done) begin
                        out_data <= adder_dataOut;
                        job_cnt  <= job_cnt + CNT_WIDTH'(1);
                    end else if (wait_last) begin
                        err_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_feeder.sv
// tb/tb_adder_tree_feeder.sv - self-checking bench for adder_tree_feeder with a behavioural adder stub
module tb_adder_tree_feeder;

    localparam int DW = 8;
    localparam int KS = 3;
    localparam int RW = 9;
    localparam int SW = 12;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rstn;
    logic            in_valid;
    logic            in_ready;
    logic [DW*KS-1:0] in_data;
    logic [KS-1:0]   in_weight;
    logic            adder_en;
    logic [RW*KS-1:0] adder_dataIn;
    logic [SW-1:0]   adder_dataOut;
    logic            adder_done;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_data;
    logic            err_timeout;
    logic [15:0]     job_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_jobs = 0;
    logic exp_err = 1'b0;

    adder_tree_feeder dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_weight    (in_weight),
        .adder_en     (adder_en),
        .adder_dataIn (adder_dataIn),
        .adder_dataOut(adder_dataOut),
        .adder_done   (adder_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .err_timeout  (err_timeout),
        .job_cnt      (job_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*KS-1:0] data;
        logic [KS-1:0]    wt;
        logic [SW-1:0]    exp_sum;
        int               lat;
        int               hold;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] model_sum(input logic [DW*KS-1:0] d, input logic [KS-1:0] w);
        int s = 0;
        for (int i = 0; i < KS; i++)
            if (w[i]) s += int'(d[i*DW +: DW]);
        return SW'(s);
    endfunction

    function automatic logic [RW*KS-1:0] model_products(input logic [DW*KS-1:0] d, input logic [KS-1:0] w);
        logic [RW*KS-1:0] p = '0;
        for (int i = 0; i < KS; i++)
            p[i*RW +: RW] = w[i] ? {1'b0, d[i*DW +: DW]} : '0;
        return p;
    endfunction

    // What the real adder_tree would return for whatever the feeder presented.
    function automatic logic [SW-1:0] stub_sum(input logic [RW*KS-1:0] p);
        int s = 0;
        for (int i = 0; i < KS; i++) s += int'(p[i*RW +: RW]);
        return SW'(s);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_adder_en"}, adder_en, 0);
        check({tag, "_dataIn"}, adder_dataIn, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_err"}, err_timeout, 0);
        check({tag, "_job_cnt"}, job_cnt, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    // Called at a negedge with the feeder idle; returns at a negedge with it idle again.
    task automatic run_job(input logic [DW*KS-1:0] d, input logic [KS-1:0] w, input logic [SW-1:0] esum,
                           input int lat, input int hold, input bit spur, input bit hang);
        logic [RW*KS-1:0] eprod;
        eprod = model_products(d, w);
        check("idle_in_ready", in_ready, 1);
        in_data = d; in_weight = w; in_valid = 1'b1;
        if (spur) begin adder_done = 1'b1; adder_dataOut = 12'hABC; end
        @(negedge clk);
        in_valid = 1'b0; in_data = 24'($urandom); in_weight = 3'($urandom);
        check("fire_adder_en", adder_en, 1);
        check("fire_dataIn", adder_dataIn, eprod);
        check("fire_in_ready", in_ready, 0);
        @(negedge clk);
        adder_done = 1'b0;
        check("wait_adder_en", adder_en, 0);
        check("wait_dataIn_held", adder_dataIn, eprod);
        if (hang) begin
            repeat (TO - 1) @(negedge clk);
            check("to_err_before", err_timeout, exp_err);
            check("to_in_ready_before", in_ready, 0);
            @(negedge clk);
            exp_err = 1'b1;
            check("to_err_after", err_timeout, 1);
            check("to_in_ready_after", in_ready, 1);
            check("to_out_valid", out_valid, 0);
            check("to_job_cnt", job_cnt, 32'(exp_jobs));
            return;
        end
        repeat (lat - 1) @(negedge clk);
        check("wait_no_out_valid", out_valid, 0);
        adder_done = 1'b1;
        adder_dataOut = stub_sum(adder_dataIn);
        @(negedge clk);
        adder_done = 1'b0;
        adder_dataOut = 12'($urandom);
        exp_jobs = (exp_jobs + 1) % 65536;
        check("out_valid", out_valid, 1);
        check("out_data", out_data, esum);
        check("job_cnt", job_cnt, 32'(exp_jobs));
        if (hold > 0) begin
            in_valid = 1'b1; in_data = 24'($urandom); in_weight = 3'b111;
            repeat (hold) @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, esum);
            check("hold_in_ready", in_ready, 0);
            check("hold_adder_en", adder_en, 0);
            check("hold_dataIn", adder_dataIn, eprod);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("done_out_valid", out_valid, 0);
        check("done_in_ready", in_ready, 1);
        check("done_err", err_timeout, exp_err);
    endtask

    initial begin
        vecs[0] = '{{8'd3, 8'd2, 8'd4}, 3'b111, 12'd9, 2, 0};
        vecs[1] = '{{8'd255, 8'd255, 8'd255}, 3'b101, 12'd510, 1, 0};
        vecs[2] = '{{8'd255, 8'd255, 8'd255}, 3'b111, 12'd765, 3, 0};
        vecs[3] = '{{8'd30, 8'd20, 8'd10}, 3'b000, 12'd0, 1, 0};
        vecs[4] = '{{8'd100, 8'd1, 8'd200}, 3'b010, 12'd1, 4, 10};
        vecs[5] = '{{8'd9, 8'd8, 8'd7}, 3'b100, 12'd9, 2, 2};

        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_weight = '0;
        adder_dataOut = '0; adder_done = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++)
            run_job(vecs[i].data, vecs[i].wt, vecs[i].exp_sum, vecs[i].lat, vecs[i].hold, 1'b0, 1'b0);

        // Stale done while idle must not be captured or counted.
        adder_done = 1'b1; adder_dataOut = 12'h7FF;
        repeat (2) @(negedge clk);
        check("stale_done_out_valid", out_valid, 0);
        check("stale_done_job_cnt", job_cnt, 32'(exp_jobs));
        run_job({8'd5, 8'd6, 8'd7}, 3'b011, 12'd13, 2, 0, 1'b1, 1'b0);

        run_job({8'd1, 8'd2, 8'd3}, 3'b111, 12'd0, 1, 0, 1'b0, 1'b1);
        run_job({8'd11, 8'd12, 8'd13}, 3'b110, 12'd23, 1, 0, 1'b0, 1'b0);

        // Reset while waiting on the adder.
        in_data = {8'd40, 8'd50, 8'd60}; in_weight = 3'b111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_jobs = 0; exp_err = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_job({8'd40, 8'd50, 8'd60}, 3'b111, 12'd150, 2, 1, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            logic [DW*KS-1:0] d;
            logic [KS-1:0] w;
            d = 24'($urandom);
            w = 3'($urandom);
            run_job(d, w, model_sum(d, w), int'($urandom_range(6, 1)), int'($urandom_range(3, 0)), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
